// File: rtl/conc_stim_player_if.sv
// Handshake and bus bundle between the concolic harness and the stimulus player.
// Carries the vector-memory write port, the playback controls and the replay outputs.
// Harness side uses master; the player uses slave.
interface conc_stim_player_if #(
    parameter int DATA_W = 8,
    parameter int REP_W  = 4,
    parameter int ADDR_W = 10,
    parameter int LCNT_W = 16
);
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W+REP_W-1:0] wr_data;
    logic                    start;
    logic                    stop;
    logic [1:0]              mode;
    logic                    step;
    logic [ADDR_W:0]         length;
    logic                    ready;
    logic [DATA_W-1:0]       stim_out;
    logic                    stim_valid;
    logic [ADDR_W-1:0]       pc;
    logic [LCNT_W-1:0]       loop_cnt;
    logic                    busy;
    logic                    done;

    modport master (
        output wr_en, wr_addr, wr_data, start, stop, mode, step, length, ready,
        input  stim_out, stim_valid, pc, loop_cnt, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, stop, mode, step, length, ready,
        output stim_out, stim_valid, pc, loop_cnt, busy, done
    );
endinterface

// File: rtl/conc_stim_player.sv
// Replays a loaded vector memory onto DUT inputs with per-entry hold, one-shot/loop/single-step.
// Latency: start at edge T gives first live word after edge T+2; entries then follow with no bubble.
// Backpressure: ready=0 freezes hold counter, pc and stim_out; stop aborts to IDLE on the next edge.
module conc_stim_player #(
    parameter int DATA_W = 8,
    parameter int REP_W  = 4,
    parameter int ADDR_W = 10,
    parameter int LCNT_W = 16
) (
    input logic              clock,
    input logic              reset,
    conc_stim_player_if.slave bus
);
    localparam int ENTRY_W = DATA_W + REP_W;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [1:0] M_ONESHOT = 2'b00;
    localparam logic [1:0] M_LOOP    = 2'b01;
    localparam logic [1:0] M_STEP    = 2'b10;

    typedef enum logic [1:0] {IDLE, FETCH, PLAY, DONE} state_t;

    logic [ENTRY_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [ENTRY_W-1:0] nxt_q;      // prefetched entry that follows the one on stim_out

    state_t             state_q;
    logic               fetch_ph;   // FETCH is two cycles: read mem[0], then load it and read the next
    logic [1:0]         mode_q;
    logic [ADDR_W-1:0]  last_q;     // index of the final entry (clamped length - 1)
    logic [REP_W-1:0]   hold_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [LCNT_W-1:0]  loop_q;
    logic [DATA_W-1:0]  stim_q;
    logic               valid_q;
    logic               busy_q;
    logic               done_q;

    logic [1:0]         mode_in;
    logic [ADDR_W:0]    len_clamped;
    logic [ADDR_W-1:0]  last_in;
    logic [ADDR_W-1:0]  pc_next;
    logic [ADDR_W-1:0]  rd_addr;
    logic               retire;
    logic               rd_en;

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] idx,
                                                   input logic [ADDR_W-1:0] last);
        return (idx == last) ? '0 : idx + ADDR_W'(1);
    endfunction

    // Decode start-time controls, retire condition and the prefetch address.
    always_comb begin
        mode_in     = (bus.mode == 2'b11) ? M_ONESHOT : bus.mode;
        len_clamped = (bus.length > DEPTH) ? DEPTH : bus.length;
        last_in     = ADDR_W'(len_clamped - (ADDR_W+1)'(1));
        pc_next     = wrap_inc(pc_q, last_q);
        retire      = (state_q == PLAY) && bus.ready &&
                      ((mode_q == M_STEP) ? bus.step : (hold_q == '0));
        rd_en       = (state_q == FETCH) || retire;
        rd_addr     = '0;
        if (state_q == FETCH) begin
            rd_addr = fetch_ph ? wrap_inc('0, last_q) : '0;
        end else begin
            rd_addr = wrap_inc(pc_next, last_q);
        end
    end

    // Vector memory write port; locked out while a playback is in progress.
    always_ff @(posedge clock) begin
        if (bus.wr_en && !busy_q) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Synchronous read into the prefetch register, one entry ahead of stim_out.
    always_ff @(posedge clock) begin
        if (rd_en) begin
            nxt_q <= mem[rd_addr];
        end
    end

    // Playback FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            fetch_ph <= 1'b0;
            mode_q   <= M_ONESHOT;
            last_q   <= '0;
            hold_q   <= '0;
            pc_q     <= '0;
            loop_q   <= '0;
            stim_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (bus.stop) begin
            state_q  <= IDLE;
            fetch_ph <= 1'b0;
            stim_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.length != '0) begin
                            mode_q   <= mode_in;
                            last_q   <= last_in;
                            pc_q     <= '0;
                            loop_q   <= '0;
                            fetch_ph <= 1'b0;
                            busy_q   <= 1'b1;
                            state_q  <= FETCH;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (!fetch_ph) begin
                        fetch_ph <= 1'b1;
                    end else begin
                        fetch_ph <= 1'b0;
                        stim_q   <= nxt_q[DATA_W-1:0];
                        hold_q   <= nxt_q[ENTRY_W-1:DATA_W];
                        valid_q  <= 1'b1;
                        state_q  <= PLAY;
                    end
                end
                PLAY: begin
                    if (retire) begin
                        if (pc_q == last_q && mode_q != M_LOOP) begin
                            stim_q  <= '0;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            if (pc_q == last_q && loop_q != '1) begin
                                loop_q <= loop_q + LCNT_W'(1);
                            end
                            pc_q   <= pc_next;
                            stim_q <= nxt_q[DATA_W-1:0];
                            hold_q <= nxt_q[ENTRY_W-1:DATA_W];
                        end
                    end else if (bus.ready && mode_q != M_STEP) begin
                        hold_q <= hold_q - REP_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.stim_out   = stim_q;
    assign bus.stim_valid = valid_q;
    assign bus.pc         = pc_q;
    assign bus.loop_cnt   = loop_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule
